// File: rtl/linked_list_reader.sv
// ---------------------------------------------------------------------------
// linked_list_reader
//
// Walks a singly linked list stored in node RAM, starting at head_ptr, and
// streams each node's payload downstream over a valid/ready interface.
// Each RAM word is {next_ptr, payload}. A pointer of all ones is NULL and
// marks the end of the chain. A traversal stops after MAX_NODES nodes, which
// protects against cyclic or corrupt chains. If the chain still continues at
// that point, err is raised together with done.
//
// Ports
//   clk, rst     clock (rising edge); asynchronous active-high reset
//   start        one-cycle request, sampled only while idle
//   head_ptr     first node address, sampled with start
//   busy         high from the accepted start until the traversal ends
//   done         one-cycle pulse at the end of a traversal
//   err          valid with done: the node limit was hit on a non-NULL link
//   node_count   nodes emitted in this traversal, held until the next start
//   mem_rd_en    node RAM read strobe
//   mem_rd_addr  node RAM read address
//   mem_rd_data  {next_ptr, payload}, valid the cycle after mem_rd_en
//   out_valid    payload valid
//   out_data     node payload
//   out_last     high with out_valid on the final node
//   out_ready    downstream accept
// ---------------------------------------------------------------------------
module linked_list_reader #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_NODES = 255,
  parameter int CNT_W     = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        head_ptr,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [CNT_W-1:0]         node_count,
  output logic                     mem_rd_en,
  output logic [ADDR_W-1:0]        mem_rd_addr,
  input  logic [ADDR_W+DATA_W-1:0] mem_rd_data,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_last,
  input  logic                     out_ready
);

  localparam logic [ADDR_W-1:0] NULL_PTR = '1;
  // Count value held while the final permitted node is being emitted.
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MAX_NODES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_OUT,
    S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic [ADDR_W-1:0]   next_ptr_reg, next_ptr_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [DATA_W-1:0]   data_reg, data_next;
  logic                last_reg, last_next;
  logic                err_reg, err_next;

  // Split of the RAM word read back in WAIT.
  logic [ADDR_W-1:0]   rd_next_ptr;
  logic [DATA_W-1:0]   rd_payload;

  assign rd_next_ptr = mem_rd_data[ADDR_W+DATA_W-1:DATA_W];
  assign rd_payload  = mem_rd_data[DATA_W-1:0];

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      ptr_reg      <= '0;
      next_ptr_reg <= '0;
      count_reg    <= '0;
      data_reg     <= '0;
      last_reg     <= 1'b0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      next_ptr_reg <= next_ptr_next;
      count_reg    <= count_next;
      data_reg     <= data_next;
      last_reg     <= last_next;
      err_reg      <= err_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and datapath update
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    next_ptr_next = next_ptr_reg;
    count_next    = count_reg;
    data_next     = data_reg;
    last_next     = last_reg;
    err_next      = err_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (start) begin
          count_next = '0;
          err_next   = 1'b0;
          if (head_ptr == NULL_PTR) begin
            // Empty list: finish without touching memory.
            state_next = S_DONE;
          end else begin
            ptr_next   = head_ptr;
            state_next = S_FETCH;
          end
        end
      end

      S_FETCH: begin
        state_next = S_WAIT;
      end

      S_WAIT: begin
        next_ptr_next = rd_next_ptr;
        data_next     = rd_payload;
        // Last is decided here so it can be presented together with the
        // payload: either the chain ends or the node limit is reached.
        last_next     = (rd_next_ptr == NULL_PTR) || (count_reg == LAST_CNT);
        state_next    = S_OUT;
      end

      S_OUT: begin
        if (out_ready) begin
          count_next = count_reg + CNT_W'(1);
          if (last_reg) begin
            // A last node with a live link can only mean the limit was hit.
            err_next   = (next_ptr_reg != NULL_PTR);
            state_next = S_DONE;
          end else begin
            ptr_next   = next_ptr_reg;
            state_next = S_FETCH;
          end
        end
      end

      S_DONE: begin
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs, decoded from the registered state so that reset clears them
  // immediately.
  // -------------------------------------------------------------------------
  always_comb begin
    busy        = (state_reg == S_FETCH) || (state_reg == S_WAIT) ||
                  (state_reg == S_OUT);
    done        = (state_reg == S_DONE);
    err         = (state_reg == S_DONE) && err_reg;
    node_count  = count_reg;
    mem_rd_en   = (state_reg == S_FETCH);
    mem_rd_addr = (state_reg == S_FETCH) ? ptr_reg : '0;
    out_valid   = (state_reg == S_OUT);
    out_data    = data_reg;
    out_last    = (state_reg == S_OUT) && last_reg;
  end

endmodule

// File: tb/tb_linked_list_reader.sv
// ---------------------------------------------------------------------------
// tb_linked_list_reader
//
// Directed and randomized traversals of linked_list_reader (MAX_NODES=4)
// against a node RAM model and a list-walking reference model.
// ---------------------------------------------------------------------------
module tb_linked_list_reader;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 16;
  localparam int MAX_NODES = 4;
  localparam int CNT_W     = 8;
  localparam logic [7:0] NULLP = 8'hFF;

  logic                     clk;
  logic                     rst;
  logic                     start;
  logic [ADDR_W-1:0]        head_ptr;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [CNT_W-1:0]         node_count;
  logic                     mem_rd_en;
  logic [ADDR_W-1:0]        mem_rd_addr;
  logic [ADDR_W+DATA_W-1:0] mem_rd_data;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic                     out_ready;

  linked_list_reader #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_NODES(MAX_NODES),
    .CNT_W    (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .head_ptr   (head_ptr),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .node_count (node_count),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_last   (out_last),
    .out_ready  (out_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Node RAM: synchronous read, data valid the cycle after the strobe.
  logic [23:0] mem [256];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  // Observed traffic, sampled on the falling edge.
  logic [15:0] got_data[$];
  bit          got_last[$];
  logic [7:0]  got_addr[$];
  bit          prev_stall = 0;
  logic [15:0] prev_data;
  bit          prev_last;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (mem_rd_en) got_addr.push_back(mem_rd_addr);
      if (prev_stall) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, prev_data);
        check("hold_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
        got_data.push_back(out_data);
        got_last.push_back(out_last);
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
    end
  end

  // out_ready driver: 0 always ready, 1 random, 2 stall 5 cycles on node 2,
  // 3 never ready.
  int rdy_mode  = 0;
  int stall_cnt = 0;
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (got_data.size() == 1 && out_valid && stall_cnt < 5) begin
            out_ready = 1'b0;
            stall_cnt++;
          end else begin
            out_ready = 1'b1;
          end
        end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Reference model: walk the list in the RAM image.
  logic [15:0] exp_data[$];
  bit          exp_last[$];
  logic [7:0]  exp_addr[$];
  int          exp_n;
  bit          exp_err;

  task automatic model_walk(input logic [7:0] head);
    logic [7:0]  p;
    logic [23:0] e;
    bit          lst;
    exp_data.delete(); exp_last.delete(); exp_addr.delete();
    exp_n = 0; exp_err = 0;
    p = head;
    while (p != NULLP) begin
      e = mem[p];
      exp_addr.push_back(p);
      exp_data.push_back(e[15:0]);
      exp_n++;
      lst = 0;
      if (e[23:16] == NULLP) lst = 1;
      else if (exp_n == MAX_NODES) begin lst = 1; exp_err = 1; end
      exp_last.push_back(lst);
      if (lst) break;
      p = e[23:16];
    end
  endtask

  task automatic run_trav(input logic [7:0] head, input int rmode, input bit inject);
    int cyc;
    model_walk(head);
    got_data.delete(); got_last.delete(); got_addr.delete();
    rdy_mode = rmode; stall_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; head_ptr = head;
    @(posedge clk); #1;
    start = 1'b0; head_ptr = 8'($urandom);
    @(negedge clk);
    if (head == NULLP) begin
      check("null_done", done, 1);
      check("null_busy", busy, 0);
      check("null_err", err, 0);
      check("null_cnt", node_count, 0);
      check("null_rd_en", mem_rd_en, 0);
      @(negedge clk);
      check("null_done_pulse", done, 0);
      check("null_nout", got_data.size(), 0);
      check("null_nrd", got_addr.size(), 0);
      return;
    end
    check("lat_rd_en", mem_rd_en, 1);
    check("lat_rd_addr", mem_rd_addr, head);
    check("lat_busy", busy, 1);
    @(negedge clk);
    check("lat_wait_valid", out_valid, 0);
    check("lat_wait_rd_en", mem_rd_en, 0);
    @(negedge clk);
    check("lat_out_valid", out_valid, 1);
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      @(posedge clk); #1;
      start = inject && (cyc == 1 || cyc == 4);
      if (start) head_ptr = 8'($urandom);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("done_seen", done, 1);
    check("done_err", err, exp_err);
    check("done_cnt", node_count, exp_n);
    check("done_busy", busy, 0);
    check("done_valid", out_valid, 0);
    check("n_out", got_data.size(), exp_data.size());
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check($sformatf("data%0d", i), got_data[i], exp_data[i]);
      check($sformatf("last%0d", i), got_last[i], exp_last[i]);
    end
    check("n_rd", got_addr.size(), exp_addr.size());
    for (int i = 0; i < exp_addr.size() && i < got_addr.size(); i++)
      check($sformatf("addr%0d", i), got_addr[i], exp_addr[i]);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("cnt_held", node_count, exp_n);
    $display("trav head=%0h nodes=%0d err=%0d ready_mode=%0d inject=%0d", head, exp_n, exp_err, rmode, inject);
  endtask

  // Random chain of len nodes; optionally the tail links back into the chain.
  task automatic build_list(input int len, input bit cyc, output logic [7:0] head);
    logic [7:0] addrs[$];
    logic [7:0] a;
    logic [7:0] nx;
    bit         used [256];
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 24'($urandom);
      used[i] = 0;
    end
    while (addrs.size() < len) begin
      a = 8'($urandom_range(0, 254));
      if (!used[a]) begin used[a] = 1; addrs.push_back(a); end
    end
    for (int i = 0; i < len; i++) begin
      if (i < len - 1) nx = addrs[i+1];
      else if (cyc)    nx = addrs[$urandom_range(0, len - 1)];
      else             nx = NULLP;
      mem[addrs[i]] = {nx, 16'($urandom)};
    end
    head = addrs[0];
  endtask

  initial begin
    logic [7:0] h;
    int         w;
    rst = 1'b1; start = 1'b0; head_ptr = '0;
    for (int i = 0; i < 256; i++) mem[i] = 24'($urandom);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt", node_count, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_rd_addr", mem_rd_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Two-node list 3 -> 7 -> NULL.
    mem[3] = {8'h07, 16'h00A1};
    mem[7] = {NULLP, 16'h00B2};
    run_trav(8'h03, 0, 0);

    // Empty list.
    run_trav(NULLP, 0, 0);

    // Three nodes with a downstream stall on node 2.
    mem[10] = {8'd20, 16'h1111};
    mem[20] = {8'd30, 16'h2222};
    mem[30] = {NULLP, 16'h3333};
    run_trav(8'd10, 2, 0);

    // Self-loop hits the node limit.
    mem[5] = {8'h05, 16'h5A5A};
    run_trav(8'h05, 0, 0);

    // Repeated start while busy is ignored.
    run_trav(8'd10, 1, 1);

    // Reset while a payload is being offered.
    mem[0] = {8'h09, 16'hC0DE};
    mem[9] = {NULLP, 16'hBEEF};
    rdy_mode = 3;
    @(posedge clk); #1;
    start = 1'b1; head_ptr = 8'h00;
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (out_valid !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("rst_mid_reach_out", out_valid, 1);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_cnt", node_count, 0);
    check("rst_mid_data", out_data, 0);
    check("rst_mid_last", out_last, 0);
    check("rst_mid_rd_addr", mem_rd_addr, 0);
    @(negedge clk);
    check("rst_mid_no_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    run_trav(8'h00, 0, 0);

    // Randomized chains, some cyclic, with random backpressure.
    for (int t = 0; t < 30; t++) begin
      build_list($urandom_range(1, 6), ($urandom_range(0, 3) == 0), h);
      run_trav(h, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
